keypad_scanner: RTL and testbench

- Scans a 4x4 key matrix; input-side counterpart of the column-multiplexed display driver.
- Drives one-hot active-high columns using the same counter-top-bits column select as the display path.
- Samples the rows, debounces whole scan frames, and reports single-key presses as a 4-bit code.
- Handshake is valid/ack towards the consuming logic.

---
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column drive, frame debounce, single-key events with valid/ack.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_FRAMES frames.
module keypad_scanner #(
    parameter int SCAN_DIV      = 15,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int          LOW = SCAN_DIV - 2;
    localparam logic [3:0]  DEB = 4'(DEBOUNCE);

    if (SCAN_DIV < 3 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : gBadParams
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;

    logic [SCAN_DIV-1:0] counter;
    logic [1:0]          col;
    logic                sampleNow;
    logic                frameEnd;
    logic [15:0]         snapshot;
    logic [15:0]         frameNext;
    logic [15:0]         prevFrame;
    logic [15:0]         debounced;
    logic [3:0]          stableCnt;
    logic [3:0]          cntNext;
    logic                frameDone;
    state_t              state;
    logic                emit;
    logic [3:0]          emitCode;
    logic [3:0]          heldCode;
    logic                oneHot;
    logic [3:0]          debIndex;

    assign col       = counter[SCAN_DIV-1 -: 2];
    assign columns   = 4'b0001 << col;
    assign sampleNow = &counter[LOW-1:0];
    assign frameEnd  = sampleNow && (col == 2'd3);

    function automatic logic [3:0] bitIndex(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // The live row sample for the current column merged over the stored snapshot;
    // at frame end this is the complete frame.
    always_comb begin
        frameNext = snapshot;
        for (int r = 0; r < 4; r++) begin
            frameNext[r*4 + int'(col)] = rows[r];
        end
    end

    always_comb begin
        cntNext = 4'd1;
        if (frameNext == prevFrame) begin
            cntNext = (stableCnt >= DEB) ? DEB : stableCnt + 4'd1;
        end
    end

    assign oneHot   = (debounced != 16'd0) && ((debounced & (debounced - 16'd1)) == 16'd0);
    assign debIndex = bitIndex(debounced);

    // Scan counter, row sampling and whole-frame debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            snapshot  <= '0;
            prevFrame <= '0;
            debounced <= '0;
            stableCnt <= '0;
            frameDone <= 1'b0;
        end else begin
            counter   <= counter + 1'b1;
            frameDone <= frameEnd;
            if (sampleNow) begin
                snapshot <= frameNext;
            end
            if (frameEnd) begin
                stableCnt <= cntNext;
                prevFrame <= frameNext;
                if (cntNext == DEB) begin
                    debounced <= frameNext;
                end
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    logic [RW-1:0] repeatCnt;
`endif

    // Key state machine, evaluated once per frame on the clock after frame end;
    // any multi-key pattern parks in LOCK until the matrix is fully released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_down <= 1'b0;
            emit     <= 1'b0;
            emitCode <= '0;
            heldCode <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            repeatCnt <= '0;
`endif
        end else begin
            emit <= 1'b0;
            if (frameDone) begin
                case (state)
                    IDLE: begin
                        if (oneHot) begin
                            state    <= HELD;
                            key_down <= 1'b1;
                            emit     <= 1'b1;
                            emitCode <= debIndex;
                            heldCode <= debIndex;
`ifdef KEYPAD_AUTOREPEAT_EN
                            repeatCnt <= '0;
`endif
                        end else if (debounced != 16'd0) begin
                            state <= LOCK;
                        end
                    end
                    HELD: begin
                        if (debounced == 16'd0) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end else if (!(oneHot && debIndex == heldCode)) begin
                            state    <= LOCK;
                            key_down <= 1'b0;
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (repeatCnt == RW'(REPEAT_FRAMES - 1)) begin
                                repeatCnt <= '0;
                                emit      <= 1'b1;
                                emitCode  <= heldCode;
                            end else begin
                                repeatCnt <= repeatCnt + 1'b1;
                            end
`endif
                        end
                    end
                    LOCK: begin
                        if (debounced == 16'd0) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Event handshake: a pending event is never overwritten unless acked in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || key_ack) begin
                key_code  <= emitCode;
                key_valid <= 1'b1;
                overrun   <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2, REPEAT_FRAMES=3).
// A key matrix model drives rows from the pressed-key map and the column drive.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  columns;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [15:0] keys = 16'd0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          events = 0;
    int          expEvents;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2), .REPEAT_FRAMES(3)) dut (
        .clk(clk), .rst_n(rst_n), .rows(rows), .columns(columns),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
        .key_down(key_down), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'd0;
        for (int r = 0; r < 4; r++) begin
            rows[r] = |(keys[r*4 +: 4] & columns);
        end
    end

    // Clock edges since reset release; a frame ends on every 16th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitFrameEnd(input int n);
        repeat (n) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % 16 != 0);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k);
        keys = k;
    endtask

    initial begin
        // Reset, async assertion mid-frame, column stepping
        @(negedge clk) rst_n = 1'b1;
        tick(6);
        checkOutput("cols_pre_reset", 16'(columns), 16'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_columns", 16'(columns), 16'h1);
        checkOutput("rst_valid", 16'(key_valid), 16'h0);
        checkOutput("rst_down", 16'(key_down), 16'h0);
        checkOutput("rst_overrun", 16'(overrun), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        checkOutput("cols_0", 16'(columns), 16'h1);
        tick(4); checkOutput("cols_1", 16'(columns), 16'h2);
        tick(4); checkOutput("cols_2", 16'(columns), 16'h4);
        tick(4); checkOutput("cols_3", 16'(columns), 16'h8);
        tick(4); checkOutput("cols_wrap", 16'(columns), 16'h1);

        // Single key row1/col2 -> code 6
        applyStimulus(16'h0040);
        waitFrameEnd(1);
        checkOutput("k6_f1_valid", 16'(key_valid), 16'h0);
        waitFrameEnd(1);
        checkOutput("k6_f2_valid", 16'(key_valid), 16'h0);
        checkOutput("k6_f2_down", 16'(key_down), 16'h0);
        tick(1);
        checkOutput("k6_down", 16'(key_down), 16'h1);
        checkOutput("k6_valid_lat1", 16'(key_valid), 16'h0);
        tick(1);
        checkOutput("k6_valid", 16'(key_valid), 16'h1);
        checkOutput("k6_code", 16'(key_code), 16'h6);
        key_ack = 1'b1; tick(1); key_ack = 1'b0;
        checkOutput("k6_ack", 16'(key_valid), 16'h0);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);
        checkOutput("k6_rel_down_hold", 16'(key_down), 16'h1);
        tick(1);
        checkOutput("k6_rel_down", 16'(key_down), 16'h0);
        checkOutput("k6_rel_valid", 16'(key_valid), 16'h0);

        // One-frame glitch is rejected
        waitFrameEnd(1);
        applyStimulus(16'h0001);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);
        tick(2);
        checkOutput("glitch_valid", 16'(key_valid), 16'h0);
        checkOutput("glitch_down", 16'(key_down), 16'h0);

        // Two keys lock out, release, then row2/col1 -> code 9
        waitFrameEnd(1);
        applyStimulus(16'h8001);
        waitFrameEnd(4);
        tick(2);
        checkOutput("lock_valid", 16'(key_valid), 16'h0);
        checkOutput("lock_down", 16'(key_down), 16'h0);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);
        applyStimulus(16'h0200);
        waitFrameEnd(2);
        tick(2);
        checkOutput("k9_valid", 16'(key_valid), 16'h1);
        checkOutput("k9_code", 16'(key_code), 16'h9);
        checkOutput("k9_down", 16'(key_down), 16'h1);
        key_ack = 1'b1; tick(1); key_ack = 1'b0;
        checkOutput("k9_ack", 16'(key_valid), 16'h0);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);

        // Overrun: code 3 pending, then code 4 is dropped
        applyStimulus(16'h0008);
        waitFrameEnd(2);
        tick(2);
        checkOutput("k3_valid", 16'(key_valid), 16'h1);
        checkOutput("k3_code", 16'(key_code), 16'h3);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);
        applyStimulus(16'h0010);
        waitFrameEnd(2);
        tick(2);
        checkOutput("ovr_flag", 16'(overrun), 16'h1);
        checkOutput("ovr_code", 16'(key_code), 16'h3);
        checkOutput("ovr_valid", 16'(key_valid), 16'h1);
        checkOutput("ovr_down", 16'(key_down), 16'h1);
        key_ack = 1'b1; tick(1); key_ack = 1'b0;
        checkOutput("ovr_ack_valid", 16'(key_valid), 16'h0);
        checkOutput("ovr_ack_flag", 16'(overrun), 16'h0);
        waitFrameEnd(1);
        applyStimulus(16'h0000);
        waitFrameEnd(2);
        tick(1);
        checkOutput("ovr_rel_down", 16'(key_down), 16'h0);
        key_ack = 1'b1; tick(1); key_ack = 1'b0;
        checkOutput("idle_ack_valid", 16'(key_valid), 16'h0);
        checkOutput("idle_ack_flag", 16'(overrun), 16'h0);

        // Held key row1/col1 -> code 5, acking every event
        waitFrameEnd(1);
        applyStimulus(16'h0020);
`ifdef KEYPAD_AUTOREPEAT_EN
        expEvents = 3;
`else
        expEvents = 1;
`endif
        while (cyc < 760) begin
            if (cyc == 688) applyStimulus(16'h0000);
            if (key_valid && !key_ack) begin
                events++;
                checkOutput("rep_code", 16'(key_code), 16'h5);
                key_ack = 1'b1;
            end else begin
                key_ack = 1'b0;
            end
            tick(1);
        end
        key_ack = 1'b0;
        checkOutput("rep_events", 16'(events), 16'(expEvents));
        checkOutput("rep_overrun", 16'(overrun), 16'h0);

        // Reset mid-frame discards a pending event (code 10)
        waitFrameEnd(1);
        applyStimulus(16'h0400);
        waitFrameEnd(2);
        tick(2);
        checkOutput("k10_valid", 16'(key_valid), 16'h1);
        checkOutput("k10_code", 16'(key_code), 16'hA);
        tick(3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_columns", 16'(columns), 16'h1);
        checkOutput("rst2_valid", 16'(key_valid), 16'h0);
        checkOutput("rst2_code", 16'(key_code), 16'h0);
        checkOutput("rst2_down", 16'(key_down), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
